// File: rtl/tod_counter_pkg.sv
// Shared types, constants and BCD helpers for the time-of-day counter.
package tod_counter_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_byte_t;

  localparam bcd_byte_t BCD_59   = 8'h59;
  localparam bcd_byte_t BCD_ZERO = 8'h00;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    COUNT = 2'd1,
    LOAD  = 2'd2
  } tod_state_t;

  function automatic logic bcd_valid(input bcd_byte_t v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic bcd_lt(input bcd_byte_t a, input bcd_byte_t b);
    return (a[7:4] < b[7:4]) || ((a[7:4] == b[7:4]) && (a[3:0] < b[3:0]));
  endfunction

  function automatic bcd_byte_t to_bcd(input int unsigned n);
    return {4'((n / 32'd10) % 32'd10), 4'(n % 32'd10)};
  endfunction

  // Successor of v, wrapping to zero after last; low digit 9 carries into the high digit.
  function automatic bcd_byte_t bcd_succ(input bcd_byte_t v, input bcd_byte_t last);
    if (v == last) begin
      return BCD_ZERO;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

endpackage

// File: rtl/tod_counter_bcd_mod_counter.sv
// Two-digit packed-BCD modulo counter; carry is the combinational wrap-out for cascading.
module bcd_mod_counter
  import tod_counter_pkg::*;
#(
  parameter int unsigned MODULUS = 60
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      inc,
  input  logic      load,
  input  bcd_byte_t load_val,
  output bcd_byte_t val,
  output logic      carry
);

  localparam bcd_byte_t LAST = to_bcd(MODULUS - 32'd1);

  assign carry = inc & ~load & (val == LAST);

  // Digit register: load beats increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      val <= BCD_ZERO;
    end else if (load) begin
      val <= load_val;
    end else if (inc) begin
      val <= bcd_succ(val, LAST);
    end else begin
      val <= val;
    end
  end

endmodule

// File: rtl/tod_counter.sv
// Time-of-day counter (hh:mm:ss packed BCD) with validated load handshake.
// Optional alarm comparator is built when TOD_ALARM_EN is defined.
module tod_counter
  import tod_counter_pkg::*;
#(
  parameter int unsigned HOUR_LIMIT = 24
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      tick,
  input  logic      run,
  input  logic      set_valid,
  output logic      set_ready,
  input  bcd_byte_t set_hh,
  input  bcd_byte_t set_mm,
  input  bcd_byte_t set_ss,
  output bcd_byte_t hour,
  output bcd_byte_t min,
  output bcd_byte_t sec,
  output logic      min_pulse,
  output logic      hour_pulse,
  output logic      day_pulse,
  output logic      set_err
`ifdef TOD_ALARM_EN
  ,
  input  bcd_byte_t alarm_hh,
  input  bcd_byte_t alarm_mm,
  input  logic      alarm_arm,
  input  logic      alarm_ack,
  output logic      alarm
`endif
);

  localparam bcd_byte_t HOUR_LIMIT_BCD = to_bcd(HOUR_LIMIT);

  tod_state_t state_r, state_s;
  logic count_en_s, accept_s, load_ok_s, load_s, inc_s;
  logic sec_carry_s, min_carry_s, hour_carry_s;

  assign accept_s  = set_valid & set_ready;
  assign load_ok_s = bcd_valid(set_ss) && !bcd_lt(BCD_59, set_ss) &&
                     bcd_valid(set_mm) && !bcd_lt(BCD_59, set_mm) &&
                     bcd_valid(set_hh) && bcd_lt(set_hh, HOUR_LIMIT_BCD);
  assign load_s    = accept_s & load_ok_s;
  // A tick arriving with an accept is dropped so the loaded value is exact.
  assign inc_s     = count_en_s & tick & ~accept_s;

  // Next state and count enable.
  always_comb begin
    state_s    = state_r;
    count_en_s = 1'b0;
    case (state_r)
      HOLD:        count_en_s = 1'b0;
      COUNT, LOAD: count_en_s = 1'b1;
      default:     count_en_s = 1'b0;
    endcase
    if (accept_s) begin
      state_s = LOAD;
    end else if (run) begin
      state_s = COUNT;
    end else begin
      state_s = HOLD;
    end
  end

  // State, handshake and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= HOLD;
      set_ready  <= 1'b0;
      set_err    <= 1'b0;
      min_pulse  <= 1'b0;
      hour_pulse <= 1'b0;
      day_pulse  <= 1'b0;
    end else begin
      state_r    <= state_s;
      set_ready  <= (state_s != LOAD);
      set_err    <= accept_s & ~load_ok_s;
      min_pulse  <= sec_carry_s;
      hour_pulse <= min_carry_s;
      day_pulse  <= hour_carry_s;
    end
  end

  bcd_mod_counter #(.MODULUS(60)) u_sec (
    .clk(clk), .reset(reset), .inc(inc_s), .load(load_s),
    .load_val(set_ss), .val(sec), .carry(sec_carry_s)
  );

  bcd_mod_counter #(.MODULUS(60)) u_min (
    .clk(clk), .reset(reset), .inc(sec_carry_s), .load(load_s),
    .load_val(set_mm), .val(min), .carry(min_carry_s)
  );

  bcd_mod_counter #(.MODULUS(HOUR_LIMIT)) u_hour (
    .clk(clk), .reset(reset), .inc(min_carry_s), .load(load_s),
    .load_val(set_hh), .val(hour), .carry(hour_carry_s)
  );

`ifdef TOD_ALARM_EN
  localparam bcd_byte_t HOUR_LAST = to_bcd(HOUR_LIMIT - 32'd1);

  bcd_byte_t next_hour_s, next_min_s;
  logic      alarm_hit_s;

  // The match is taken against the post-update value so alarm rises with hh:mm:00.
  assign next_min_s  = sec_carry_s ? bcd_succ(min, BCD_59) : min;
  assign next_hour_s = min_carry_s ? bcd_succ(hour, HOUR_LAST) : hour;
  assign alarm_hit_s = alarm_arm & sec_carry_s &
                       (next_hour_s == alarm_hh) & (next_min_s == alarm_mm);

  // Sticky alarm flag; a new hit wins over a same-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm <= 1'b0;
    end else if (alarm_hit_s) begin
      alarm <= 1'b1;
    end else if (alarm_ack) begin
      alarm <= 1'b0;
    end else begin
      alarm <= alarm;
    end
  end
`endif

endmodule

// File: tb/tb_tod_counter.sv
// Directed table-driven bench for tod_counter; alarm sequence added under TOD_ALARM_EN.
module tb_tod_counter;

  logic       clk = 1'b0;
  logic       reset, tick, run, set_valid, set_ready;
  logic [7:0] set_hh, set_mm, set_ss, hour, min, sec;
  logic       min_pulse, hour_pulse, day_pulse, set_err;
`ifdef TOD_ALARM_EN
  logic [7:0] alarm_hh, alarm_mm;
  logic       alarm_arm, alarm_ack, alarm;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tod_counter #(.HOUR_LIMIT(24)) dut (
    .clk(clk), .reset(reset), .tick(tick), .run(run),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .hour(hour), .min(min), .sec(sec),
    .min_pulse(min_pulse), .hour_pulse(hour_pulse), .day_pulse(day_pulse),
    .set_err(set_err)
`ifdef TOD_ALARM_EN
    ,
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm),
    .alarm_ack(alarm_ack), .alarm(alarm)
`endif
  );

  typedef struct {
    logic        rst, run, tick, vld;
    logic [23:0] set_t;
    logic [23:0] exp_t;
    logic [2:0]  exp_p;
    logic        exp_err, exp_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic r, input logic t, input logic v,
                     input logic [23:0] st, input logic [23:0] et, input logic [2:0] ep,
                     input logic ee, input logic er);
    vec_t x;
    x.rst = rst; x.run = r; x.tick = t; x.vld = v; x.set_t = st;
    x.exp_t = et; x.exp_p = ep; x.exp_err = ee; x.exp_rdy = er;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic r, input logic t, input logic v,
                       input logic [23:0] st);
    reset = rst; run = r; tick = t; set_valid = v;
    set_hh = st[23:16]; set_mm = st[15:8]; set_ss = st[7:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int pulses;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
`ifdef TOD_ALARM_EN
    alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_arm = 1'b0; alarm_ack = 1'b0;
`endif
    //   rst   run   tick  vld   set          expect time  {m,h,d} err   rdy
    add(1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 24'h235958, 24'h235958, 3'b000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h235959, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h235959, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h235959, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000, 3'b111, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000001, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b1, 24'h123456, 24'h123456, 3'b000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h123457, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 24'h12345A, 24'h123457, 3'b000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h123457, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 24'h240000, 24'h123457, 3'b000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h123457, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b1, 24'h1F0000, 24'h123457, 3'b000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h123458, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 24'h006000, 24'h123458, 3'b000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 24'h010203, 24'h123458, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 24'h095959, 24'h095959, 3'b000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h100000, 3'b110, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 24'h235959, 24'h235959, 3'b000, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000001, 3'b000, 1'b0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].run, vecs[i].tick, vecs[i].vld, vecs[i].set_t);
      step();
      chk($sformatf("v%0d time", i), {8'h00, hour, min, sec}, {8'h00, vecs[i].exp_t});
      chk($sformatf("v%0d pulses", i), {29'd0, min_pulse, hour_pulse, day_pulse},
          {29'd0, vecs[i].exp_p});
      chk($sformatf("v%0d set_err", i), {31'd0, set_err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d set_ready", i), {31'd0, set_ready}, {31'd0, vecs[i].exp_rdy});
    end

    // Sixty ticks from midnight: one minute, exactly one min_pulse.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
    step();
    pulses = 0;
    tick = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (min_pulse === 1'b1) pulses++;
    end
    tick = 1'b0;
    chk("minute time", {8'h00, hour, min, sec}, 32'h00000100);
    chk("minute pulse count", pulses, 32'd1);
    step();
    chk("minute pulse cleared", {31'd0, min_pulse}, 32'd0);

`ifdef TOD_ALARM_EN
    alarm_arm = 1'b1;
    chk("alarm idle", {31'd0, alarm}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 24'h072958);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h000000);
    step();
    chk("alarm 07:29:59", {31'd0, alarm}, 32'd0);
    step();
    chk("alarm time", {8'h00, hour, min, sec}, 32'h00073000);
    chk("alarm rise", {31'd0, alarm}, 32'd1);
    tick = 1'b0;
    step();
    step();
    chk("alarm hold", {31'd0, alarm}, 32'd1);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("alarm ack", {31'd0, alarm}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 24'h072959);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h000000);
    alarm_ack = 1'b1;
    step();
    chk("alarm set beats ack", {31'd0, alarm}, 32'd1);
    alarm_ack = 1'b0;
    tick = 1'b0;
    step();
    chk("alarm held after ack", {31'd0, alarm}, 32'd1);
    reset = 1'b1;
    step();
    chk("alarm reset", {31'd0, alarm}, 32'd0);
    reset = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
